// File: rtl/fifo_n_base_if.sv
// Enqueue/dequeue/status bundle for fifo_n_base.
// master = producer/consumer side, slave = FIFO side.
interface fifo_n_base_if #(
    parameter int width = 32,
    parameter int depth = 4
);
    localparam int cw = $clog2(depth) + 1;

    logic             enq_ena;
    logic [width-1:0] enq_v;
    logic             enq_rdy;
    logic             deq_ena;
    logic             deq_rdy;
    logic [width-1:0] first;
    logic             first_rdy;
    logic [cw-1:0]    count;
    logic             almost_full;
    logic             almost_empty;

    modport master (
        output enq_ena, enq_v, deq_ena,
        input  enq_rdy, deq_rdy, first, first_rdy, count, almost_full, almost_empty
    );

    modport slave (
        input  enq_ena, enq_v, deq_ena,
        output enq_rdy, deq_rdy, first, first_rdy, count, almost_full, almost_empty
    );
endinterface

// File: rtl/fifo_n_base.sv
// N-entry first-word-fall-through FIFO: ring buffer with a separate occupancy
// counter, almost-full/almost-empty flags, synchronous flush and an optional
// pipelined mode that accepts an enqueue into a full FIFO while it dequeues.
module fifo_n_base #(
    parameter int width     = 32,
    parameter int depth     = 4,
    parameter int pipelined = 0,
    parameter int af_level  = depth - 1,
    parameter int ae_level  = 1
) (
    input  logic          CLK,
    input  logic          nRST,
    input  logic          clear,
    fifo_n_base_if.slave  bus
);
    localparam int pw = $clog2(depth);
    localparam int cw = pw + 1;

    logic [width-1:0] storage [depth];
    logic [pw-1:0]    rd_ptr;
    logic [pw-1:0]    wr_ptr;
    logic [cw-1:0]    cnt;

    logic full;
    logic empty;
    logic enq_ok;
    logic enq_fire;
    logic deq_fire;

    // Handshake decode; in pipelined mode a same-cycle dequeue frees the slot
    // for the incoming word, which makes deq_ena -> enq_rdy combinational.
    always_comb begin
        full     = (cnt == cw'(depth));
        empty    = (cnt == '0);
        enq_ok   = !full || ((pipelined != 0) && bus.deq_ena);
        enq_fire = bus.enq_ena && enq_ok;
        deq_fire = bus.deq_ena && !empty;
    end

    assign bus.enq_rdy      = enq_ok;
    assign bus.deq_rdy      = !empty;
    assign bus.first_rdy    = !empty;
    assign bus.first        = storage[rd_ptr];
    assign bus.count        = cnt;
    assign bus.almost_full  = (cnt >= cw'(af_level));
    assign bus.almost_empty = (cnt <= cw'(ae_level));

    // Pointer/count/storage update; reset beats clear, clear beats traffic,
    // and clear leaves the storage contents alone.
    always_ff @(posedge CLK) begin
        if (!nRST) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            cnt    <= '0;
            for (int i = 0; i < depth; i++) begin
                storage[i] <= '0;
            end
        end else if (clear) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            cnt    <= '0;
        end else begin
            if (enq_fire) begin
                storage[wr_ptr] <= bus.enq_v;
                wr_ptr          <= wr_ptr + pw'(1);
            end
            if (deq_fire) begin
                rd_ptr <= rd_ptr + pw'(1);
            end
            case ({enq_fire, deq_fire})
                2'b10:   cnt <= cnt + cw'(1);
                2'b01:   cnt <= cnt - cw'(1);
                default: cnt <= cnt;
            endcase
        end
    end
endmodule

// File: doc/fifo_n_base.md
Name: fifo_n_base

Overview:
- Parametrised N-entry, first-word-fall-through FIFO; successor to the single-element pipe FIFO.
- Generalised in width and depth.
- Adds occupancy count, almost-full/almost-empty flags, synchronous clear, and an optional pipelined mode (enqueue into a full FIFO while it dequeues).
- Sits between producer/consumer modules on ENA/RDY enq/deq/first channels.

Parameters:
width, 32, data bits per entry (>=1)
depth, 4, number of entries; power of two, >=2
pipelined, 0, 1 = enq_rdy also asserted when full and deq_ena is high in the same cycle
af_level, depth-1, almost_full asserts when count >= af_level (1..depth)
ae_level, 1, almost_empty asserts when count <= ae_level (0..depth-1)

Ports:
CLK  input  1  clock; all state updates on posedge
nRST  input  1  synchronous reset, active low
clear  input  1  synchronous flush, active high
enq_ena  input  1  enqueue request
enq_v  input  width  enqueue data
enq_rdy  output  1  enqueue accepted when enq_ena && enq_rdy
deq_ena  input  1  dequeue request
deq_rdy  output  1  dequeue allowed (count != 0)
first  output  width  head-of-queue data
first_rdy  output  1  first valid (== deq_rdy)
count  output  $clog2(depth)+1  current occupancy
almost_full  output  1  count >= af_level
almost_empty  output  1  count <= ae_level

Behaviour:
- Interface: reset nRST, synchronous, active-low; clock CLK.
- Reset (nRST=0 at posedge):
  - rd_ptr, wr_ptr, count <- 0; storage <- 0.
  - Outputs after reset: enq_rdy=1, deq_rdy=0, first_rdy=0, first=0, count=0, almost_full=0, almost_empty=1.
  - Reset overrides clear, enq and deq.
- Storage:
  - Ring buffer of depth entries; pointers are log2(depth) bits and wrap naturally from depth-1 to 0.
  - count is held separately, so full and empty are never ambiguous.
- enq_rdy:
  - = (count != depth) when pipelined=0.
  - = (count != depth) || deq_ena when pipelined=1. This is a combinational path deq_ena -> enq_rdy.
- deq_rdy = first_rdy = (count != 0).
- first = storage[rd_ptr], combinational read, valid whenever first_rdy=1. No bypass: data enqueued in cycle t is visible on first in cycle t+1 at the earliest.
- Accepted enq (enq_ena && enq_rdy): storage[wr_ptr] <- enq_v; wr_ptr++.
- Accepted deq (deq_ena && deq_rdy): rd_ptr++.
- count update:
  - +1 on enq only; -1 on deq only.
  - Unchanged on simultaneous accepted enq+deq, including the full+pipelined case and depth wrap.
- Requests without the matching rdy are ignored; no state change and no error.
- Simultaneous enq+deq when empty: deq is ignored (deq_rdy=0); enq proceeds and count becomes 1.
- clear=1 at posedge (nRST=1):
  - rd_ptr, wr_ptr, count <- 0.
  - Any same-cycle enq/deq is discarded.
  - Storage contents are untouched.
- almost_full and almost_empty are combinational from count.
- Latency: enq-to-first 1 cycle; throughput 1 entry/cycle in each direction.
- Invariant for the bench: 0 <= count <= depth at all times. Output order equals input order.

Test Plan:
- Reset, then fill: depth=4, enq 0xA0..0xA3 on 4 consecutive cycles -> count 1,2,3,4; enq_rdy=0 after the 4th; almost_full=1 from count=3; first=0xA0.
- Drain: with 4 entries, deq 4 cycles -> first shows 0xA0, A1, A2, A3 in order; count 3..0; deq_rdy=0 and almost_empty=1 at the end; a 5th deq is ignored.
- Pointer wrap: 10 cycles of simultaneous enq/deq at count=2 -> count stays 2; data order preserved across the 0xB0..0xB9 wrap.
- Full with pipelined=1: count=4, enq 0xC0 + deq same cycle -> enq accepted, count stays 4, 0xC0 appears last. With pipelined=0 the same stimulus -> enq rejected, count=3.
- Clear mid-traffic: count=3, clear with enq 0xD0 + deq same cycle -> count=0, deq_rdy=0. Next enq 0xD1 -> first=0xD1 one cycle later.
- Reset mid-operation: count=2, nRST=0 for one cycle with clear=1 and enq active -> all outputs at reset values. The next enq works normally.
